// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared types and constants for the MIPS datapath blocks.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Fetch unit states; ERR is reachable only when IFU_TIMEOUT_EN is defined
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } ifu_state_t;

  // Default byte address of the first instruction after reset
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/ifu_wdog.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_wdog
//  Brief    : Fetch wait counter. Counts REQ cycles without ack and flags
//             expiry in the TIMEOUT-th unacknowledged cycle.
//  Revision : 1.0  initial release
// ============================================================================
module ifu_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // Counter is held at zero outside REQ, so it starts from zero on every entry
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      wait_cnt <= '0;
    end else if (!ack) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // An ack in the final allowed cycle wins over expiry
  assign expired = active && !ack && (wait_cnt == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ifu
//  Brief    : Instruction fetch unit. Owns the PC, fetches one word per
//             instruction over a req/ack handshake and holds it stable until
//             the datapath commits with Adv.
//             Optional fetch timeout enabled by defining IFU_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module ifu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:2] NPC,
  input  logic        Adv,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:2] PC,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] icnt,
  output logic        err
);

  ifu_state_t state;
  logic       timeout;

`ifdef IFU_TIMEOUT_EN
  ifu_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state == REQ),
    .ack     (imem_ack),
    .expired (timeout)
  );

  assign err = (state == ERR);
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT == 0);
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Handshake and valid flags come straight from the state register
  assign imem_req   = (state == REQ);
  assign InstrValid = (state == VALID);
  assign imem_addr  = PC;

  // Fetch state machine with PC, instruction and commit counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      PC    <= RESET_PC[31:2];
      Instr <= '0;
      icnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            Instr <= imem_rdata;
            state <= VALID;
          end else if (timeout) begin
            state <= ERR;
          end
        end
        VALID: begin
          if (Adv) begin
            PC    <= NPC;
            icnt  <= icnt + 32'd1;
            state <= REQ;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit for the MIPS datapath: owns the PC register, issues word fetches to instruction memory over a req/ack handshake, and holds the fetched instruction stable for decode and the next-PC logic. It consumes the word-addressed next PC produced by the next-PC logic and returns the current PC plus instruction word, which feeds that logic's `dout` input. It sits between instruction memory and the rest of the datapath.

## Interface
- `RESET_PC`, 32'h0000_3000, byte address loaded into PC on reset; bits [1:0] ignored.
- `TIMEOUT`, 16, fetch wait limit in cycles; used only with IFU_TIMEOUT_EN.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `NPC`  in  [31:2]  next word address from next-PC logic.
- `Adv`  in  1  datapath has finished the current instruction; commit NPC.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  [31:2]  fetch word address; always equals `PC`.
- `imem_ack`  in  1  memory returns data this cycle.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ack`=1.
- `PC`  out  [31:2]  current word address.
- `Instr`  out  32  current instruction word (to decode and next-PC `dout`).
- `InstrValid`  out  1  `Instr` belongs to `PC` and may execute.
- `icnt`  out  32  count of committed instructions.
- `err`  out  1  fetch timeout, sticky; tied 0 without IFU_TIMEOUT_EN.

## Operation
- States: IDLE, REQ, VALID, and ERR (ERR only with IFU_TIMEOUT_EN).
- Reset: sampled `rst_n`=0 at an edge sets state=IDLE, `PC`=RESET_PC[31:2], `Instr`=0, `InstrValid`=0, `icnt`=0, `err`=0.
- IDLE -> REQ unconditionally. Only reset enters IDLE.
- REQ: `imem_req`=1 and `imem_addr`=`PC`, both held stable until ack. An ack sampled high captures `imem_rdata` into `Instr` and moves to VALID.
- VALID: `InstrValid`=1, `imem_req`=0, and `Instr` and `PC` are frozen.
  - `Adv`=1: `PC` <= `NPC`, `icnt` <= `icnt`+1 (wraps at 2^32), state goes to REQ.
  - `Adv`=0: state holds indefinitely.
- `Adv` is ignored outside VALID. `imem_ack` is ignored outside REQ.
- `NPC` is sampled only at the committing edge. No range or alignment checks are applied to it.
- `PC` wraps naturally at the 30-bit boundary.

## Timing
- `imem_req` and `InstrValid` are decoded from the state register, so they are glitch-free with respect to `Adv` and `NPC`.
- Memory may ack in the same cycle `req` rises (combinational memory).
- Minimum time per instruction is 2 cycles: one in REQ, one in VALID with `Adv`=1.
- First request occurs in the cycle after the first edge with `rst_n`=1.
- Reset mid-fetch: an outstanding request is abandoned, and any ack arriving in IDLE is ignored.
- An ack coinciding with a reset edge is discarded.

## Configuration
- `IFU_TIMEOUT_EN` defined:
  - A wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - When TIMEOUT consecutive REQ cycles pass without ack, the state goes to ERR at that edge.
  - In ERR: `err`=1, `imem_req`=0, `InstrValid`=0. The state is sticky until reset, and late acks are ignored.
  - An ack in the TIMEOUT-th cycle still counts as success.
- `IFU_TIMEOUT_EN` undefined: no counter and no ERR state, `err`=0, and REQ waits forever.

## Structure
- Shared package `mips_pkg`:
  - state enum `ifu_state_t` (IDLE, REQ, VALID, ERR);
  - default reset PC constant `RESET_PC_DEF` = 32'h0000_3000.
- Sub-module `ifu_wdog`: the wait counter and timeout compare. It is instantiated only under `IFU_TIMEOUT_EN`.

## Test plan
- Reset, then zero-wait memory. Required: first `imem_addr`=0x0C00 (byte 0x3000); `InstrValid` in cycle 3 after release; with `Adv` tied 1 and `NPC`=`PC`+1, one instruction commits every 2 cycles and `icnt`=5 after 10 cycles.
- Ack after 3 wait cycles. Required: `imem_req` and `imem_addr` stay constant for 4 cycles; `Instr`=`imem_rdata` captured at the ack edge, for example 0x1000_0003.
- Branch: `NPC`=0x0C40 with `Adv`=1 in VALID. Required: next `imem_addr`=0x0C40; `PC` does not change while `Adv`=0.
- Stall: `Adv`=0 for 5 cycles in VALID while `imem_rdata` and `imem_ack` toggle. Required: `Instr`, `PC` and `icnt` remain unchanged.
- `rst_n` pulsed low during REQ with an ack in the same cycle. Required: `PC`=0x0C00, `Instr`=0, `icnt`=0, and the next request re-fetches 0x0C00.
- With `IFU_TIMEOUT_EN` and TIMEOUT=16, no ack. Required: `err` rises at the 16th REQ edge, `imem_req` drops, and a late ack does not set `InstrValid`.
